// File: rtl/mode_ctrl.sv
// mode_ctrl: two-button major/minor mode selector with an "increase" button
// that supports press-and-hold auto-repeat, plus an idle timeout that drops
// an active minor mode back to minor 0 (the general display minor).
//
// Ports
//   clk       clock, all state updates on the rising edge
//   reset_n   asynchronous active-low reset
//   sw1       raw level, major-mode advance button
//   sw2       raw level, minor-mode advance button
//   set       raw level, increase button
//   mode1     current major mode (registered)
//   mode2     current minor mode (registered), 0 = general minor
//   increase  single-cycle increment pulse (registered)
//   timeout   single-cycle pulse on the cycle the idle revert takes effect
module mode_ctrl #(
  parameter int                   N_MAJOR     = 4,
  parameter int                   MW          = 2,
  parameter logic [4*N_MAJOR-1:0] MINOR_CNT   = 16'h3334,
  parameter logic [N_MAJOR-1:0]   EDIT_EN     = 4'b1101,
  parameter int                   REPEAT_DLY  = 8,
  parameter int                   REPEAT_RATE = 4,
  parameter int                   IDLE_TO     = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sw1,
  input  logic                       sw2,
  input  logic                       set,
  output logic [$clog2(N_MAJOR)-1:0] mode1,
  output logic [MW-1:0]              mode2,
  output logic                       increase,
  output logic                       timeout
);

  localparam int M1W      = $clog2(N_MAJOR);
  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int IW       = $clog2(IDLE_TO + 1);

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_WAIT   = 2'd1,
    H_REPEAT = 2'd2
  } hold_t;

  hold_t           hold_st;
  logic [HW-1:0]   hold_cnt;
  logic [IW-1:0]   idle_cnt;

  logic            sw1_p0, sw2_p0, set_p0;
  logic            sw1_p1, sw2_p1, set_p1;
  logic            armed;

  logic            sw1_e, sw2_e, set_e, any_edge;
  logic            edit;
  logic            to_fire;
  logic            hold_exit;

  function automatic logic [M1W-1:0] next_major(input logic [M1W-1:0] m1);
    if (m1 == M1W'(N_MAJOR - 1)) return '0;
    return m1 + M1W'(1);
  endfunction

  // Wrap point depends on the minor count of the current major.
  function automatic logic [MW-1:0] next_minor(input logic [M1W-1:0] m1,
                                               input logic [MW-1:0]  m2);
    int last;
    last = int'(MINOR_CNT[4*m1 +: 4]) - 1;
    if (int'(m2) >= last) return '0;
    return m2 + MW'(1);
  endfunction

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (v == '1) ? v : v + HW'(1);
  endfunction

  function automatic logic [IW-1:0] sat_inc_i(input logic [IW-1:0] v);
    return (v == '1) ? v : v + IW'(1);
  endfunction

  // Stage p0: buttons registered once; stage p1: previous value for edge detect.
  // On the first clock after reset both stages load the live level, so a
  // button held through reset release does not count as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw1_p0 <= 1'b0;
      sw2_p0 <= 1'b0;
      set_p0 <= 1'b0;
      sw1_p1 <= 1'b0;
      sw2_p1 <= 1'b0;
      set_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sw1_p0 <= sw1;
      sw2_p0 <= sw2;
      set_p0 <= set;
      if (armed) begin
        sw1_p1 <= sw1_p0;
        sw2_p1 <= sw2_p0;
        set_p1 <= set_p0;
      end else begin
        sw1_p1 <= sw1;
        sw2_p1 <= sw2;
        set_p1 <= set;
      end
      armed <= 1'b1;
    end
  end

  assign sw1_e    = sw1_p0 & ~sw1_p1;
  assign sw2_e    = sw2_p0 & ~sw2_p1;
  assign set_e    = set_p0 & ~set_p1;
  assign any_edge = sw1_e | sw2_e | set_e;

  assign edit      = (mode2 != '0) && EDIT_EN[mode1];
  assign hold_exit = !set_p0 || sw1_e || sw2_e || !edit;

  // Any button edge restarts the idle window, so a sw2 press always beats
  // a timeout landing in the same cycle.
  assign to_fire = !any_edge && (mode2 != '0) && (hold_st == H_IDLE) &&
                   (idle_cnt == IW'(IDLE_TO - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode1    <= '0;
      mode2    <= '0;
      increase <= 1'b0;
      timeout  <= 1'b0;
      hold_st  <= H_IDLE;
      hold_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      increase <= 1'b0;
      timeout  <= to_fire;

      // Simultaneous sw1 and sw2 edges cancel each other.
      if (sw1_e && !sw2_e) begin
        mode1 <= next_major(mode1);
        mode2 <= '0;
      end else if (sw2_e && !sw1_e) begin
        mode2 <= next_minor(mode1, mode2);
      end else if (to_fire) begin
        mode2 <= '0;
      end

      if (any_edge || to_fire || (mode2 == '0)) begin
        idle_cnt <= '0;
      end else if (hold_st == H_IDLE) begin
        idle_cnt <= sat_inc_i(idle_cnt);
      end

      // Repeat pulses that would land right after another pulse hold the
      // counter at its terminal value and fire one cycle later instead.
      case (hold_st)
        H_IDLE: begin
          hold_cnt <= '0;
          if (set_e && edit && !sw1_e && !sw2_e) begin
            hold_st  <= H_WAIT;
            increase <= 1'b1;
          end
        end
        H_WAIT: begin
          if (hold_exit) begin
            hold_st  <= H_IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt >= HW'(REPEAT_DLY - 1)) begin
            if (!increase) begin
              increase <= 1'b1;
              hold_st  <= H_REPEAT;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= sat_inc_h(hold_cnt);
          end
        end
        H_REPEAT: begin
          if (hold_exit) begin
            hold_st  <= H_IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt >= HW'(REPEAT_RATE - 1)) begin
            if (!increase) begin
              increase <= 1'b1;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= sat_inc_h(hold_cnt);
          end
        end
        default: begin
          hold_st  <= H_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with default parameters:
// minor counts {3,3,3,4} for majors {3,2,1,0}; major 1 is the only non-edit
// major under EDIT_EN = 4'b1101.
module tb_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       set = 1'b0;
  logic [1:0] mode1;
  logic [1:0] mode2;
  logic       increase;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mode_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw1      (sw1),
    .sw2      (sw2),
    .set      (set),
    .mode1    (mode1),
    .mode2    (mode2),
    .increase (increase),
    .timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press on the selected buttons, then two settle cycles.
  task automatic press(input logic a, input logic b, input logic s);
    sw1 = a; sw2 = b; set = s;
    tick();
    sw1 = 1'b0; sw2 = 1'b0; set = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m2a[5] = '{1, 2, 3, 0, 1};
    int m2b[3] = '{1, 2, 0};
    int n_to;
    int inc_seen;
    logic [1:0] m2_at64;

    repeat (3) tick();
    check("rst_mode1", mode1, 0);
    check("rst_mode2", mode2, 0);
    check("rst_increase", increase, 0);
    check("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    tick();
    tick();

    // Major stepping wraps and clears the minor.
    for (int i = 1; i <= 4; i++) begin
      press(1'b1, 1'b0, 1'b0);
      check($sformatf("sw1_mode1_%0d", i), mode1, i % 4);
      check($sformatf("sw1_mode2_%0d", i), mode2, 0);
    end

    // Major 0 has four minors.
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 1'b0);
      check($sformatf("m0_mode2_%0d", i), mode2, m2a[i]);
      check($sformatf("m0_mode1_%0d", i), mode1, 0);
    end

    // Major 1 has three minors.
    press(1'b1, 1'b0, 1'b0);
    check("to_m1_mode1", mode1, 1);
    check("to_m1_mode2", mode2, 0);
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, 1'b0);
      check($sformatf("m1_mode2_%0d", i), mode2, m2b[i]);
    end

    // Non-edit major: set gives no increase, idle revert after 64 idle cycles.
    press(1'b0, 1'b1, 1'b0);
    check("ne_mode2_pre", mode2, 1);
    set = 1'b1;
    tick();                      // set edge cycle E
    set = 1'b0;
    n_to = 0;
    inc_seen = 0;
    m2_at64 = 2'd3;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (increase) inc_seen++;
      if (n == 64) m2_at64 = mode2;
      if (timeout) begin
        n_to = n;
        break;
      end
    end
    check("ne_no_increase", inc_seen, 0);
    check("ne_mode2_before_to", m2_at64, 1);
    check("ne_timeout_at", n_to, 65);
    check("ne_mode2_after_to", mode2, 0);
    tick();
    check("ne_timeout_single", timeout, 0);

    // Back to major 0, minor 1 (edit state).
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("back_m0", mode1, 0);
    press(1'b0, 1'b1, 1'b0);
    check("edit_mode2", mode2, 1);

    // Hold set for 20 registered cycles: pulses at T+1, T+9, T+13, T+17.
    set = 1'b1;
    tick();                      // edge cycle T
    for (int i = 1; i <= 25; i++) begin
      tick();
      check($sformatf("hold_inc_T%0d", i), increase,
            (i == 1 || i == 9 || i == 13 || i == 17) ? 1 : 0);
      if (i == 19) set = 1'b0;
    end

    // Simultaneous sw1/sw2 edges are ignored.
    press(1'b1, 1'b1, 1'b0);
    check("both_mode1", mode1, 0);
    check("both_mode2", mode2, 1);

    // set rising with sw2: minor advances, no increase even while held.
    sw2 = 1'b1; set = 1'b1;
    tick();
    sw2 = 1'b0;
    inc_seen = 0;
    repeat (12) begin
      tick();
      if (increase) inc_seen++;
    end
    check("setsw2_no_increase", inc_seen, 0);
    check("setsw2_mode2", mode2, 2);
    set = 1'b0;
    tick();
    tick();

    // Reset in the middle of auto-repeat, with sw1 held through release.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("m2_mode1", mode1, 2);
    check("m2_mode2", mode2, 1);
    set = 1'b1;
    tick();                      // edge cycle T
    repeat (13) tick();          // T+13 is a repeat pulse
    check("pre_rst_increase", increase, 1);
    sw1 = 1'b1;
    set = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_mode1", mode1, 0);
    check("arst_mode2", mode2, 0);
    check("arst_increase", increase, 0);
    check("arst_timeout", timeout, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("held_sw1_mode1", mode1, 0);
    sw1 = 1'b0;
    repeat (3) tick();
    check("released_sw1_mode1", mode1, 0);
    press(1'b1, 1'b0, 1'b0);
    check("repress_sw1_mode1", mode1, 1);
    check("repress_sw1_mode2", mode2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
